// File: rtl/dm_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dm_responder_pkg;

   localparam int DM_DATA_WIDTH = 32;
   localparam int CNT_WIDTH     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage : dm_responder_pkg

// File: rtl/dm_responder_if.sv
// MEM-stage data access bus between the CPU (master) and the responder (slave).
interface dm_responder_if
   import dm_responder_pkg::*;
#(
   parameter int DATA_WIDTH = DM_DATA_WIDTH
) ();

   logic                  req;
   logic                  mem_write;
   logic [31:0]           address;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  err;
   logic                  stall;

   modport master (
      output req, mem_write, address, data_in,
      input  ready, data_out, err, stall
   );

   modport slave (
      input  req, mem_write, address, data_in,
      output ready, data_out, err, stall
   );

endinterface : dm_responder_if

// File: rtl/dm_array.sv
// Word storage: synchronous write, combinational read.
module dm_array #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

   // NOTE: storage has no reset; clearing it would turn the array into flops
   // and contents are expected to survive a pipeline reset.
   always_ff @(posedge clock) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule : dm_array

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: accepts one word access in IDLE, waits
// WAIT_CYCLES, commits on the edge into RESP and pulses ready for one cycle.
module dm_responder
   import dm_responder_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2,
   parameter int DATA_WIDTH  = DM_DATA_WIDTH
) (
   input  logic          clock,
   input  logic          reset,
   dm_responder_if.slave bus
);

   localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(WAIT_CYCLES);

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  wr_q, wr_d;
   logic [31:0]           addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  ready_q, ready_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;

   logic                  acc_wr;
   logic [31:0]           acc_addr;
   logic [DATA_WIDTH-1:0] acc_wdata;
   logic                  acc_err;
   logic                  commit;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [DATA_WIDTH-1:0] rdata;

   // With zero wait states the commit edge is also the accept edge, so the
   // access fields come straight from the bus while still in IDLE.
   assign acc_wr    = (state_q == IDLE) ? bus.mem_write : wr_q;
   assign acc_addr  = (state_q == IDLE) ? bus.address   : addr_q;
   assign acc_wdata = (state_q == IDLE) ? bus.data_in   : wdata_q;

   assign word_idx = acc_addr[ADDR_WIDTH+1:2];
   assign acc_err  = (acc_addr[1:0] != 2'b00) ||
                     (acc_addr[31:ADDR_WIDTH+2] != '0);

   assign commit = (state_d == RESP) && (state_q != RESP);
   assign mem_we = commit && acc_wr && !acc_err;

   dm_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_array (
      .clock (clock),
      .we    (mem_we),
      .waddr (word_idx),
      .wdata (acc_wdata),
      .raddr (word_idx),
      .rdata (rdata)
   );

   // NOTE: every variable gets its hold value first so no path through the
   // case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      unique case (state_q)
         IDLE: begin
            if (bus.req) begin
               wr_d    = bus.mem_write;
               addr_d  = bus.address;
               wdata_d = bus.data_in;
               cnt_d   = CNT_LOAD;
               state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_WIDTH'(1)) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready_d = commit;
      err_d   = commit && acc_err;
      dout_d  = dout_q;
      if (commit) begin
         if (acc_err) begin
            dout_d = '0;
         end else if (!acc_wr) begin
            dout_d = rdata;
         end
      end
   end

   // NOTE: non-blocking assignments keep every register sampling the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         dout_q  <= dout_d;
      end
   end

   assign bus.ready    = ready_q;
   assign bus.err      = err_q;
   assign bus.data_out = dout_q;
   assign bus.stall    = bus.req & ~ready_q;

endmodule : dm_responder

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Multi-cycle data-memory responder: the slave end of the MEM-stage data access issued by the pipeline CPU.
- Replaces the single-cycle data memory with a wait-state, handshake-driven responder.
- Exports a stall to the hazard controller so the pipeline freezes until the access completes.
- Word-only accesses. Flags misaligned and out-of-range accesses.

Parameters:
- ADDR_WIDTH, 10, word-address bits; storage depth = 2^ADDR_WIDTH words.
- WAIT_CYCLES, 2, wait states between accept and response (0..15).
- DATA_WIDTH, 32, data word width.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  access request from MEM stage; held high until ready.
- mem_write  input  1  1 = store, 0 = load; sampled with req.
- address  input  32  byte address (alu result).
- data_in  input  DATA_WIDTH  store data (forwarded rt value).
- ready  output  1  one-cycle completion pulse.
- data_out  output  DATA_WIDTH  load data; held until the next response.
- err  output  1  access error, valid while ready=1.
- stall  output  1  combinational req & ~ready; feeds hazard control (freeze PC, IF/ID, ID/EXE, EXE/MEM).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; ready=0; data_out=0; err=0; internal latches and counter = 0.
  - Storage array is NOT cleared.
  - stall follows req during reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Samples req.
  - If req=1: latch mem_write, address, data_in; load cnt=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - cnt decrements each cycle.
  - When cnt==1, next state is RESP.
  - Occupies exactly WAIT_CYCLES cycles.
  - req/address changes during WAIT are ignored (latched copy used).
- Commit at the clock edge entering RESP:
  - Store: mem[word] <= latched data; data_out unchanged.
  - Load: data_out <= mem[word].
- RESP:
  - ready=1 for exactly one cycle.
  - The CPU advances on this edge.
  - Next state is IDLE unconditionally.
  - req seen in RESP is never accepted; a new request is accepted only in IDLE (minimum one IDLE cycle between accesses).
- Latency: req accepted in cycle 0 gives ready in cycle WAIT_CYCLES+1.
- Word index = address[ADDR_WIDTH+1:2].
- Error conditions:
  - Misaligned (address[1:0]!=0), or out of range (address[31:ADDR_WIDTH+2]!=0).
  - No write occurs; data_out <= 0; err=1 during RESP.
  - err is 0 in all other cycles.
- A load following a store to the same word returns the stored value (store committed before the later load's commit edge).
- Reset asserted mid-access (WAIT): the access is abandoned and no write occurs. Reset asserted in RESP: the write has already happened.
- req deasserted during WAIT (e.g. flush): the access still completes; the ready pulse is harmless.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and the DATA_WIDTH default.
- Sub-module dm_array: synchronous-write, combinational-read storage.
  - Ports: clock, we, waddr, wdata, raddr, rdata.
  - Instantiated once.
- FSM, counter, error check and output registers stay in dm_responder.

Test Plan:
- Store then load, WAIT_CYCLES=2:
  - req=1, mem_write=1, address=0x10, data_in=0xDEADBEEF at cycle 0 gives ready at cycle 3 (stall=1 in cycles 0-2).
  - Load of 0x10 requested at cycle 4 gives ready at cycle 7 with data_out=0xDEADBEEF, err=0.
- WAIT_CYCLES=0: load of an address preloaded with 0x12345678, requested at cycle 0, gives ready=1 at cycle 1 with data_out=0x12345678; stall=1 only in cycle 0.
- Misaligned store to address=0x13, data 0xFFFFFFFF: ready with err=1, data_out=0. A subsequent load of 0x10 still returns the prior contents.
- Out-of-range load to address=0x1000 (ADDR_WIDTH=10): err=1, data_out=0, no hang, back to IDLE.
- Reset mid-access: store to 0x20 of 0xAAAA5555 with reset pulsed low in the WAIT cycle gives ready=0, state IDLE, no write. A later load of 0x20 returns the original value.
- Back-to-back: req held high across RESP gives no second acceptance in RESP; the next access starts from IDLE one cycle later. address changed during WAIT does not alter the accessed word.
